// File: rtl/apb_pwm_bank_pkg.sv
// Shared register map, CTRL bit positions and APB address decode for the PWM bank.
package apb_pwm_bank_pkg;

  localparam int unsigned APB_AW = 8;
  localparam int unsigned APB_DW = 32;

  localparam logic [7:0] OFF_IRQ_STAT = 8'h00;
  localparam logic [7:0] OFF_GLB_EN   = 8'h04;
  localparam logic [7:0] CH_BASE      = 8'h10;
  localparam logic [7:0] CH_STRIDE    = 8'h10;

  localparam logic [3:0] OFF_PERIOD = 4'h0;
  localparam logic [3:0] OFF_DUTY   = 4'h4;
  localparam logic [3:0] OFF_CTRL   = 4'h8;
  localparam logic [3:0] OFF_CNT    = 4'hC;

  localparam int unsigned CTRL_EN     = 0;
  localparam int unsigned CTRL_INV    = 1;
  localparam int unsigned CTRL_IRQ_EN = 2;
  localparam int unsigned CTRL_W      = 3;

  typedef enum logic [2:0] {
    REG_NONE,
    REG_IRQ_STAT,
    REG_GLB_EN,
    REG_PERIOD,
    REG_DUTY,
    REG_CTRL,
    REG_CNT
  } reg_sel_e;

  typedef struct packed {
    reg_sel_e   sel;
    logic [2:0] ch;
    logic       err;
  } apb_dec_t;

  // Map a byte address to a register; err flags unmapped, missing channels and CNT writes.
  function automatic apb_dec_t apb_decode(input logic [7:0] addr, input logic write,
                                          input int unsigned num_ch);
    apb_dec_t   d;
    logic [7:0] slot;
    d.sel = REG_NONE;
    d.ch  = 3'd0;
    d.err = 1'b1;
    slot  = (addr - CH_BASE) / CH_STRIDE;
    if (addr == OFF_IRQ_STAT) begin
      d.sel = REG_IRQ_STAT;
      d.err = 1'b0;
    end else if (addr == OFF_GLB_EN) begin
      d.sel = REG_GLB_EN;
      d.err = 1'b0;
    end else if ((addr >= CH_BASE) && (32'(slot) < num_ch)) begin
      d.ch  = slot[2:0];
      d.err = 1'b0;
      case (addr[3:0])
        OFF_PERIOD: d.sel = REG_PERIOD;
        OFF_DUTY:   d.sel = REG_DUTY;
        OFF_CTRL:   d.sel = REG_CTRL;
        OFF_CNT: begin
          d.sel = REG_CNT;
          d.err = write;
        end
        default:    d.err = 1'b1;
      endcase
    end
    return d;
  endfunction

endpackage

// File: rtl/apb_pwm_bank_channel.sv
// One PWM channel: shadow and active period/duty, counter, comparator and output flop.
module apb_pwm_bank_channel
  import apb_pwm_bank_pkg::*;
#(
  parameter int unsigned CNT_W = 24
) (
  input  logic             PCLK,
  input  logic             PRESET,
  input  logic             active,
  input  logic             invert,
  input  logic             wr_period,
  input  logic             wr_duty,
  input  logic [CNT_W-1:0] wdata,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] duty,
  output logic [CNT_W-1:0] cnt,
  output logic             pwm,
  output logic             wrap_c
);

  logic [CNT_W-1:0] act_period;
  logic [CNT_W-1:0] act_duty;

  assign wrap_c = active && (cnt == act_period);

  // Software-visible shadow registers
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      period <= '0;
      duty   <= '0;
    end else begin
      if (wr_period) period <= wdata;
      if (wr_duty)   duty   <= wdata;
    end
  end

  // Counter; active values reload only at the wrap or while disabled, so pulses never glitch
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      cnt        <= '0;
      act_period <= '0;
      act_duty   <= '0;
    end else if (!active || wrap_c) begin
      cnt        <= '0;
      act_period <= period;
      act_duty   <= duty;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Registered output; idle level is the inverted-inactive level
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) pwm <= 1'b0;
    else        pwm <= active ? ((cnt < act_duty) ^ invert) : invert;
  end

endmodule

// File: rtl/apb_pwm_bank.sv
// APB3 bank of NUM_CH PWM channels with global enable and combined wrap interrupt.
module apb_pwm_bank
  import apb_pwm_bank_pkg::*;
#(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned CNT_W  = 24
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [APB_AW-1:0] PADDR,
  input  logic [APB_DW-1:0] PWDATA,
  output logic [APB_DW-1:0] PRDATA,
  output logic              PREADY,
  output logic              PSLVERR,
  output logic [NUM_CH-1:0] PWM_OUT,
  output logic              IRQ
);

  apb_dec_t          dec;
  logic              wr_en;
  logic              rd_setup;
  logic              glb_en;
  logic [NUM_CH-1:0] irq_stat;
  logic [NUM_CH-1:0] irq_stat_nxt;
  logic [NUM_CH-1:0] irq_en_nxt;
  logic [NUM_CH-1:0] w1c;
  logic [NUM_CH-1:0] wrap_c;
  logic [NUM_CH-1:0] wr_period_c;
  logic [NUM_CH-1:0] wr_duty_c;
  logic [APB_DW-1:0] rdata_c;
  logic [CTRL_W-1:0] ctrl     [NUM_CH];
  logic [CTRL_W-1:0] ctrl_nxt [NUM_CH];
  logic [CNT_W-1:0]  sh_period[NUM_CH];
  logic [CNT_W-1:0]  sh_duty  [NUM_CH];
  logic [CNT_W-1:0]  cnt      [NUM_CH];
  logic              unused_pwdata;

  assign dec           = apb_decode(PADDR, PWRITE, NUM_CH);
  assign wr_en         = PSEL && PENABLE && PWRITE && !dec.err;
  assign rd_setup      = PSEL && !PENABLE && !PWRITE;
  assign PREADY        = 1'b1;
  assign unused_pwdata = ^PWDATA;

  // Write strobes, next CTRL/IRQ state and read mux
  always_comb begin
    rdata_c     = '0;
    wr_period_c = '0;
    wr_duty_c   = '0;
    irq_en_nxt  = '0;
    for (int n = 0; n < NUM_CH; n++) begin
      ctrl_nxt[n] = ctrl[n];
      if (dec.ch == 3'(n)) begin
        if (wr_en) begin
          case (dec.sel)
            REG_PERIOD: wr_period_c[n] = 1'b1;
            REG_DUTY:   wr_duty_c[n]   = 1'b1;
            REG_CTRL:   ctrl_nxt[n]    = PWDATA[CTRL_W-1:0];
            default:    ;
          endcase
        end
        case (dec.sel)
          REG_PERIOD: rdata_c = 32'(sh_period[n]);
          REG_DUTY:   rdata_c = 32'(sh_duty[n]);
          REG_CTRL:   rdata_c = 32'(ctrl[n]);
          REG_CNT:    rdata_c = 32'(cnt[n]);
          default:    ;
        endcase
      end
      irq_en_nxt[n] = ctrl_nxt[n][CTRL_IRQ_EN];
    end
    case (dec.sel)
      REG_IRQ_STAT: rdata_c = 32'(irq_stat);
      REG_GLB_EN:   rdata_c = 32'(glb_en);
      default:      ;
    endcase
    w1c          = (wr_en && (dec.sel == REG_IRQ_STAT)) ? PWDATA[NUM_CH-1:0] : '0;
    irq_stat_nxt = (irq_stat & ~w1c) | wrap_c;
  end

  // Control, status and interrupt registers; a wrap set beats a same-cycle W1C
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      glb_en   <= 1'b0;
      irq_stat <= '0;
      IRQ      <= 1'b0;
      for (int n = 0; n < NUM_CH; n++) ctrl[n] <= '0;
    end else begin
      if (wr_en && (dec.sel == REG_GLB_EN)) glb_en <= PWDATA[0];
      irq_stat <= irq_stat_nxt;
      IRQ      <= |(irq_stat_nxt & irq_en_nxt);
      for (int n = 0; n < NUM_CH; n++) ctrl[n] <= ctrl_nxt[n];
    end
  end

  // Read data captured in setup, error flag raised for the access phase only
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      PRDATA  <= '0;
      PSLVERR <= 1'b0;
    end else begin
      if (rd_setup) PRDATA <= dec.err ? '0 : rdata_c;
      PSLVERR <= PSEL && !PENABLE && dec.err;
    end
  end

  // Channel instances
  for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
    apb_pwm_bank_channel #(.CNT_W(CNT_W)) u_ch (
      .PCLK      (PCLK),
      .PRESET    (PRESET),
      .active    (ctrl[n][CTRL_EN] & glb_en),
      .invert    (ctrl[n][CTRL_INV]),
      .wr_period (wr_period_c[n]),
      .wr_duty   (wr_duty_c[n]),
      .wdata     (PWDATA[CNT_W-1:0]),
      .period    (sh_period[n]),
      .duty      (sh_duty[n]),
      .cnt       (cnt[n]),
      .pwm       (PWM_OUT[n]),
      .wrap_c    (wrap_c[n])
    );
  end

endmodule

// File: tb/tb_apb_pwm_bank.sv
// Randomized APB traffic against a cycle-stepped behavioural model of the PWM bank.
module tb_apb_pwm_bank;

  localparam int NUM_CH = 4;
  localparam int CNT_W  = 24;

  logic              PCLK, PRESET, PSEL, PENABLE, PWRITE, PREADY, PSLVERR, IRQ;
  logic [7:0]        PADDR;
  logic [31:0]       PWDATA, PRDATA;
  logic [NUM_CH-1:0] PWM_OUT;

  int vectors = 0;
  int errors  = 0;

  // model state
  logic [CNT_W-1:0]  m_shp[NUM_CH], m_shd[NUM_CH], m_actp[NUM_CH], m_actd[NUM_CH], m_cnt[NUM_CH];
  logic [2:0]        m_ctrl[NUM_CH];
  logic [NUM_CH-1:0] m_stat, m_pwm;
  logic              m_glb;
  logic [31:0]       m_prdata;

  apb_pwm_bank #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
    .PCLK(PCLK), .PRESET(PRESET), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .PWM_OUT(PWM_OUT), .IRQ(IRQ)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // rg: -1 IRQ_STAT, -2 GLB_EN, 0..3 PERIOD/DUTY/CTRL/CNT of channel ch
  function automatic void decode_addr(input logic [7:0] a, input bit w,
                                      output bit err, output int ch, output int rg);
    int ai;
    ai  = int'(a);
    err = 1'b1;
    ch  = 0;
    rg  = -3;
    if (ai % 4 != 0) return;
    if (ai == 0) begin rg = -1; err = 1'b0; end
    else if (ai == 4) begin rg = -2; err = 1'b0; end
    else if (ai >= 16 && (ai / 16 - 1) < NUM_CH) begin
      ch  = ai / 16 - 1;
      rg  = (ai % 16) / 4;
      err = (rg == 3) && w;
    end
  endfunction

  function automatic logic [31:0] model_read(input int ch, input int rg);
    case (rg)
      -1:      return 32'(m_stat);
      -2:      return 32'(m_glb);
      0:       return 32'(m_shp[ch]);
      1:       return 32'(m_shd[ch]);
      2:       return 32'(m_ctrl[ch]);
      3:       return 32'(m_cnt[ch]);
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic m_irq();
    for (int n = 0; n < NUM_CH; n++)
      if (m_stat[n] && m_ctrl[n][2]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    for (int n = 0; n < NUM_CH; n++) begin
      m_shp[n] = '0; m_shd[n] = '0; m_actp[n] = '0; m_actd[n] = '0;
      m_cnt[n] = '0; m_ctrl[n] = '0;
    end
    m_stat = '0; m_pwm = '0; m_glb = 1'b0; m_prdata = '0;
  endtask

  // Advance the model by one clock using the inputs currently on the bus
  task automatic model_step();
    bit                err, wr;
    int                ch, rg;
    logic [NUM_CH-1:0] wraps, clr;
    if (PRESET) begin
      model_reset();
      return;
    end
    decode_addr(PADDR, PWRITE, err, ch, rg);
    wr = PSEL && PENABLE && PWRITE && !err;
    if (PSEL && !PENABLE && !PWRITE) m_prdata = err ? 32'd0 : model_read(ch, rg);
    wraps = '0;
    for (int n = 0; n < NUM_CH; n++) begin
      bit on;
      on = m_ctrl[n][0] && m_glb;
      m_pwm[n] = on ? ((m_cnt[n] < m_actd[n]) ^ m_ctrl[n][1]) : m_ctrl[n][1];
      if (on && m_cnt[n] == m_actp[n]) wraps[n] = 1'b1;
      if (!on || wraps[n]) begin
        m_cnt[n]  = '0;
        m_actp[n] = m_shp[n];
        m_actd[n] = m_shd[n];
      end else begin
        m_cnt[n] = m_cnt[n] + 1;
      end
    end
    clr    = (wr && rg == -1) ? PWDATA[NUM_CH-1:0] : '0;
    m_stat = (m_stat & ~clr) | wraps;
    if (wr) begin
      case (rg)
        -2: m_glb      = PWDATA[0];
        0:  m_shp[ch]  = PWDATA[CNT_W-1:0];
        1:  m_shd[ch]  = PWDATA[CNT_W-1:0];
        2:  m_ctrl[ch] = PWDATA[2:0];
        default: ;
      endcase
    end
  endtask

  task automatic cycle();
    model_step();
    @(posedge PCLK);
    #1;
    check("pwm_out", 32'(PWM_OUT), 32'(m_pwm));
    check("irq", 32'(IRQ), 32'(m_irq()));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic apb_write(input logic [7:0] addr, input logic [31:0] data);
    bit err;
    int ch, rg;
    decode_addr(addr, 1'b1, err, ch, rg);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = addr; PWDATA = data;
    cycle();
    check("pslverr_wr", 32'(PSLVERR), 32'(err));
    PENABLE = 1'b1;
    cycle();
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic apb_read(input logic [7:0] addr, output logic [31:0] data);
    bit err;
    int ch, rg;
    decode_addr(addr, 1'b0, err, ch, rg);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = addr;
    cycle();
    check("pslverr_rd", 32'(PSLVERR), 32'(err));
    check("prdata", PRDATA, m_prdata);
    data = PRDATA;
    PENABLE = 1'b1;
    cycle();
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic count_high(input int ch, input int n, output int hi);
    hi = 0;
    for (int i = 0; i < n; i++) begin
      cycle();
      hi += int'(PWM_OUT[ch]);
    end
  endtask

  task automatic wait_cnt0(input int val);
    int g;
    g = 0;
    while (int'(m_cnt[0]) != val && g < 200) begin
      cycle();
      g++;
    end
    check("wait_cnt0", 32'(g < 200), 32'd1);
  endtask

  initial begin
    logic [31:0] rd;
    int          hi, g;
    PRESET = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = '0; PWDATA = '0;
    model_reset();
    idle(3);
    check("rst_prdata", PRDATA, 32'd0);
    check("rst_pslverr", 32'(PSLVERR), 32'd0);
    check("pready", 32'(PREADY), 32'd1);
    PRESET = 1'b0;
    idle(2);

    // basic 3-high / 7-low waveform
    apb_write(8'h10, 32'd9);
    apb_write(8'h14, 32'd3);
    apb_write(8'h18, 32'd1);
    apb_write(8'h04, 32'd1);
    idle(20);
    count_high(0, 10, hi);
    check("t1_high", 32'(hi), 32'd3);

    // mid-period duty change takes effect after the wrap
    wait_cnt0(5);
    apb_write(8'h14, 32'd7);
    idle(20);
    count_high(0, 10, hi);
    check("t2_high", 32'(hi), 32'd7);

    // duty boundaries and invert
    apb_write(8'h14, 32'd0);  idle(20); count_high(0, 10, hi); check("t3_duty0", 32'(hi), 32'd0);
    apb_write(8'h14, 32'd20); idle(20); count_high(0, 10, hi); check("t3_duty20", 32'(hi), 32'd10);
    apb_write(8'h18, 32'd3);  idle(20); count_high(0, 10, hi); check("t3_inv20", 32'(hi), 32'd0);
    apb_write(8'h14, 32'd0);  idle(20); count_high(0, 10, hi); check("t3_inv0", 32'(hi), 32'd10);
    apb_write(8'h14, 32'd3);
    apb_write(8'h18, 32'd5);
    idle(20);
    check("t4_irq_set", 32'(IRQ), 32'd1);

    // W1C away from the wrap clears, on the wrap it loses to the set
    wait_cnt0(2);
    apb_write(8'h00, 32'd1);
    check("t4_irq_clr", 32'(IRQ), 32'd0);
    wait_cnt0(8);
    apb_write(8'h00, 32'd1);
    check("t4_irq_keep", 32'(IRQ), 32'd1);
    apb_read(8'h00, rd);
    check("t4_stat_keep", rd & 32'd1, 32'd1);
    wait_cnt0(2);
    apb_write(8'h00, 32'hF);

    // counter readback and error responses
    apb_read(8'h1C, rd);
    check("t5_cnt_range", 32'(rd <= 32'd9), 32'd1);
    apb_write(8'h1C, 32'd5);
    apb_read(8'h80, rd);
    check("t5_err_rd_zero", rd, 32'd0);
    apb_read(8'h11, rd);
    apb_read(8'h08, rd);
    apb_write(8'h90, 32'hFFFF_FFFF);

    // randomized traffic
    for (int i = 0; i < 900; i++) begin
      int op, ch, rg;
      op = int'($urandom_range(0, 5));
      ch = int'($urandom_range(0, NUM_CH - 1));
      case (op)
        0: begin
          rg = int'($urandom_range(0, 2));
          case (rg)
            0:       apb_write(8'(16 + 16 * ch), $urandom_range(0, 12));
            1:       apb_write(8'(20 + 16 * ch), $urandom_range(0, 15));
            default: apb_write(8'(24 + 16 * ch), $urandom);
          endcase
        end
        1: begin
          rg = int'($urandom_range(0, 4));
          if (rg == 4) apb_read(8'h00, rd);
          else         apb_read(8'(16 + 16 * ch + 4 * rg), rd);
        end
        2: begin
          if ($urandom_range(0, 1) == 0) apb_read(8'($urandom_range(0, 255)), rd);
          else apb_write(8'($urandom_range(0, 255)), $urandom & 32'h0000_000F);
        end
        3: apb_write(8'h00, $urandom);
        4: idle(int'($urandom_range(1, 8)));
        default: apb_write(8'h04, 32'($urandom_range(0, 7) != 0));
      endcase
    end

    // async reset in the middle of a high pulse
    apb_write(8'h04, 32'd1);
    apb_write(8'h10, 32'd9);
    apb_write(8'h14, 32'd3);
    apb_write(8'h18, 32'd5);
    idle(25);
    g = 0;
    while (PWM_OUT[0] !== 1'b1 && g < 50) begin
      cycle();
      g++;
    end
    check("t6_wait_high", 32'(g < 50), 32'd1);
    #2;
    PRESET = 1'b1;
    model_reset();
    #1;
    check("t6_pwm_drop", 32'(PWM_OUT), 32'd0);
    check("t6_irq_drop", 32'(IRQ), 32'd0);
    check("t6_prdata_drop", PRDATA, 32'd0);
    cycle();
    PRESET = 1'b0;
    cycle();
    apb_read(8'h00, rd);
    apb_read(8'h04, rd);
    check("t6_glb_zero", rd, 32'd0);
    for (int n = 0; n < NUM_CH; n++)
      for (int r = 0; r < 4; r++) begin
        apb_read(8'(16 + 16 * n + 4 * r), rd);
        check("t6_reg_zero", rd, 32'd0);
      end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
